// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage / DMA requesters, the data-memory arbiter
// and the single-port data RAM macro.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 19
);
  // cpu (MEM stage) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // dma / debug port
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  // RAM macro side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus RAM: drive requests and RAM read data, observe the rest
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: cpu has priority, dma is forced after STARVE_MAX
// consecutive contested cpu wins. Read data from the synchronous RAM is routed
// back to whichever port issued the read one cycle earlier.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 19,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_d;
  logic              pend_valid;
  logic              pend_valid_d;
  owner_e            pend_owner;
  owner_e            pend_owner_d;

  logic              cpu_gnt_c;
  logic              dma_gnt_c;
  logic              contested_c;
  logic              force_dma_c;
  logic              cpu_rvalid_c;
  logic              dma_rvalid_c;
  logic [ADDR_W-1:0] mux_addr_c;
  logic [DATA_W-1:0] mux_wdata_c;

  // Grant decision: one winner per cycle, nothing granted while in reset
  always_comb begin
    cpu_gnt_c   = 1'b0;
    dma_gnt_c   = 1'b0;
    contested_c = 1'b0;
    force_dma_c = 1'b0;
    if (!reset) begin
      contested_c = bus.cpu_req & bus.dma_req;
      force_dma_c = contested_c & (starve_cnt == CNT_MAX);
      cpu_gnt_c   = bus.cpu_req & ~force_dma_c;
      dma_gnt_c   = bus.dma_req & ~cpu_gnt_c;
    end
  end

  // Next-state: starvation counter and pending-read tracking
  always_comb begin
    starve_cnt_d = starve_cnt;
    pend_valid_d = 1'b0;
    pend_owner_d = OWN_CPU;
    if (!bus.dma_req || dma_gnt_c) begin
      starve_cnt_d = '0;
    end else if (contested_c && cpu_gnt_c && (starve_cnt != CNT_MAX)) begin
      starve_cnt_d = starve_cnt + CNT_W'(1);
    end
    pend_valid_d = (cpu_gnt_c & ~bus.cpu_we) | (dma_gnt_c & ~bus.dma_we);
    pend_owner_d = dma_gnt_c ? OWN_DMA : OWN_CPU;
  end

  // State register; reset drops any read still in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      pend_valid <= 1'b0;
      pend_owner <= OWN_CPU;
    end else begin
      starve_cnt <= starve_cnt_d;
      pend_valid <= pend_valid_d;
      pend_owner <= pend_owner_d;
    end
  end

  // RAM command mux from the granted port; idle bus is all zeros
  always_comb begin
    mux_addr_c  = '0;
    mux_wdata_c = '0;
    if (cpu_gnt_c) begin
      mux_addr_c  = bus.cpu_addr;
      mux_wdata_c = bus.cpu_wdata;
    end else if (dma_gnt_c) begin
      mux_addr_c  = bus.dma_addr;
      mux_wdata_c = bus.dma_wdata;
    end
  end

  // Port outputs: grants, stall, RAM command and read-data steering
  always_comb begin
    cpu_rvalid_c   = pend_valid & (pend_owner == OWN_CPU);
    dma_rvalid_c   = pend_valid & (pend_owner == OWN_DMA);
    bus.cpu_gnt    = cpu_gnt_c;
    bus.dma_gnt    = dma_gnt_c;
    bus.cpu_stall  = bus.cpu_req & ~cpu_gnt_c & ~reset;
    bus.mem_en     = cpu_gnt_c | dma_gnt_c;
    bus.mem_we     = (cpu_gnt_c & bus.cpu_we) | (dma_gnt_c & bus.dma_we);
    bus.mem_addr   = mux_addr_c;
    bus.mem_wdata  = mux_wdata_c;
    bus.cpu_rvalid = cpu_rvalid_c;
    bus.dma_rvalid = dma_rvalid_c;
    bus.cpu_rdata  = cpu_rvalid_c ? bus.mem_rdata : '0;
    bus.dma_rdata  = dma_rvalid_c ? bus.mem_rdata : '0;
  end

endmodule
